obj_list_walker: RTL
====================

Name: obj_list_walker

Overview:
- Sits directly upstream of the ISP parameter parser.
- Walks one tile's object list in VRAM: fetches each 32-bit entry, follows link pointers, and decodes strip, triangle-array and quad-array entries.
- Hands the parser one primitive descriptor per entry: parameter address, type, strip mask/count, shadow, skip.
- Stops at end-of-list and pulses done.

Parameters:
- ADDR_W, 24, VRAM byte-address width.
- MAX_ENTRIES, 1024, guard limit on entries fetched per list; reaching it terminates the walk with an error.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- list_start  in  1  one-cycle pulse; begin walking at list_addr (ignored while busy)
- list_addr  in  ADDR_W  byte address of first object list entry (bits[1:0] forced to 0)
- param_base  in  ADDR_W  PARAM_BASE register, sampled on list_start
- vram_rd  out  1  read request, held until vram_ack
- vram_addr  out  ADDR_W  read address, stable while vram_rd=1
- vram_din  in  32  read data, valid when vram_ack=1
- vram_ack  in  1  read completion strobe
- prim_valid  out  1  descriptor available
- prim_ready  in  1  parser accepts descriptor
- prim_addr  out  ADDR_W  param_base + (offset<<2)
- prim_type  out  2  0=strip, 1=tri array, 2=quad array
- prim_mask  out  6  strip mask, bit5 = triangle 0 (strips only; 0 otherwise)
- prim_count  out  4  array count-1 (arrays only; 0 for strips)
- prim_shadow  out  1  two-volume flag
- prim_skip  out  3  vertex skip field
- list_busy  out  1  walk in progress
- list_done  out  1  one-cycle pulse at end of walk
- list_err  out  1  one-cycle pulse, coincident with list_done, for a reserved entry or guard overflow

Behaviour:
- Reset: every output 0; state IDLE; entry counter 0.
- Entry decode:
  - entry[31]=0 → strip: mask=[30:25], shadow=[24], skip=[23:21], offset=[20:0].
  - [31:29]=100 → tri array; [31:29]=101 → quad array. For both: count=[28:25], shadow=[24], skip=[23:21], offset=[20:0].
  - [31:29]=111 → link: [28]=1 means end-of-list; otherwise next address = {[23:2],2'b00}.
  - [31:29]=110 → reserved: terminate with list_err.
- prim_addr arithmetic is modulo 2^ADDR_W (wraps silently).
- FSM states: IDLE, FETCH, DECODE, EMIT, FINISH.
  - IDLE: on list_start, latch list_addr and param_base, set busy → FETCH.
  - FETCH: vram_rd=1 with vram_addr=cur. On vram_ack, latch vram_din and increment the entry counter → DECODE.
  - DECODE (1 cycle):
    - strip with mask=0 → cur+=4, FETCH (nothing emitted).
    - strip/array → load descriptor regs, EMIT.
    - link, not end → cur=next, FETCH.
    - link end, or reserved → FINISH.
    - Entry counter reaching MAX_ENTRIES forces FINISH with err, regardless of entry type.
  - EMIT: prim_valid=1; descriptor fields are stable until handshake. When prim_valid & prim_ready: cur+=4 → FETCH. prim_ready asserted before valid has no effect.
  - FINISH: list_done=1 (plus list_err if applicable), busy=0 → IDLE.
- Latency: list_start to first vram_rd is 1 cycle. DECODE to prim_valid is 1 cycle. One entry per (ack latency + 2) cycles minimum.
- vram_rd deasserts the cycle after vram_ack. The block never reads and emits at the same time (no prefetch).
- list_start while busy: ignored. list_start in the same cycle as list_done: ignored; the block reaches IDLE on the next cycle.
- An ack outside FETCH is ignored.
- Reset mid-walk: all state is cleared immediately. An in-flight read is dropped; its late ack is ignored because the block is in IDLE.

Decomposition:
- Shared package pvr_pkg:
  - entry-type constants (TYPE_STRIP/TRI/QUAD/RSVD/LINK).
  - prim_type encodings.
  - field bit positions.
  - descriptor struct shared with the ISP parser.
- One natural sub-module: ol_entry_decode, purely combinational: entry word + param_base → descriptor fields, kind, next address.
- FSM and counters stay in the top.

Test Plan:
- param_base=0x100000; list at 0x2000 = {0x7E00_0010, 0xF000_0000}; ack latency 2 → one strip: prim_addr=0x100040, mask=6'h3F; then list_done, no err. Total 2 vram reads at 0x2000 and 0x2004.
- Entries {0x8A00_0020 (tri, count=5), 0xA200_0008 (quad, count=1), 0xF000_0000}; prim_ready held low 10 cycles → descriptors stable while waiting. Emitted in order: type 1/count 5/addr base+0x80, then type 2/count 1/addr base+0x20.
- Link chain: 0x2000 = 0xE000_3000 → fetch at 0x3000 = 0x4000_0004 (strip, mask=6'h20), then 0x3004 = 0xF000_0000 → single prim, addresses read 0x2000, 0x3000, 0x3004.
- Strip with mask 0 (0x0000_0005) followed by end → no prim_valid, list_done only.
- Reserved entry 0xC000_0000 → list_done and list_err both pulse, no prim. Separately, MAX_ENTRIES=4 with self-link 0xE000_2000 at 0x2000 → err after 4th ack.
- Assert reset_n low during FETCH with ack pending; release, deliver stray ack → outputs stay 0. Then list_start walks normally.

Source files
------------

// File: rtl/pvr_pkg.sv
// Shared object-list definitions: entry tags, field positions, primitive
// type encodings and the descriptor handed to the ISP parameter parser.
package pvr_pkg;

    typedef enum logic [2:0] {
        TYPE_STRIP,
        TYPE_TRI,
        TYPE_QUAD,
        TYPE_RSVD,
        TYPE_LINK
    } entry_kind_e;

    localparam logic [1:0] PRIM_STRIP = 2'd0;
    localparam logic [1:0] PRIM_TRI   = 2'd1;
    localparam logic [1:0] PRIM_QUAD  = 2'd2;

    localparam logic [2:0] TAG_TRI  = 3'b100;
    localparam logic [2:0] TAG_QUAD = 3'b101;
    localparam logic [2:0] TAG_RSVD = 3'b110;

    localparam int unsigned F_LINK_END = 28;
    localparam int unsigned F_MASK_LSB = 25;
    localparam int unsigned F_SHADOW   = 24;
    localparam int unsigned F_SKIP_LSB = 21;
    localparam int unsigned F_OFFSET_W = 21;

    // Address is carried beside the struct because its width is a module parameter.
    typedef struct packed {
        logic [1:0] ptype;
        logic [5:0] mask;
        logic [3:0] count;
        logic       shadow;
        logic [2:0] skip;
    } prim_desc_t;

endpackage

// File: rtl/ol_entry_decode.sv
// Combinational decode of one object-list word into a primitive descriptor,
// its parameter address, the entry kind and the link target.
module ol_entry_decode
    import pvr_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic [31:0]       i_entry,
    input  logic [ADDR_W-1:0] i_param_base,
    output prim_desc_t        o_desc,
    output logic [ADDR_W-1:0] o_prim_addr,
    output entry_kind_e       o_kind,
    output logic              o_link_end,
    output logic [ADDR_W-1:0] o_next_addr
);

    assign o_prim_addr = i_param_base + ADDR_W'({i_entry[F_OFFSET_W-1:0], 2'b00});
    assign o_next_addr = ADDR_W'({i_entry[23:2], 2'b00});

    always_comb begin
        o_desc        = '0;
        o_kind        = TYPE_STRIP;
        o_link_end    = 1'b0;
        o_desc.shadow = i_entry[F_SHADOW];
        o_desc.skip   = i_entry[F_SKIP_LSB +: 3];
        if (!i_entry[31]) begin
            o_desc.ptype = PRIM_STRIP;
            o_desc.mask  = i_entry[F_MASK_LSB +: 6];
        end else begin
            unique case (i_entry[31:29])
                TAG_TRI: begin
                    o_kind       = TYPE_TRI;
                    o_desc.ptype = PRIM_TRI;
                    o_desc.count = i_entry[F_MASK_LSB +: 4];
                end
                TAG_QUAD: begin
                    o_kind       = TYPE_QUAD;
                    o_desc.ptype = PRIM_QUAD;
                    o_desc.count = i_entry[F_MASK_LSB +: 4];
                end
                TAG_RSVD: o_kind = TYPE_RSVD;
                default: begin
                    o_kind     = TYPE_LINK;
                    o_link_end = i_entry[F_LINK_END];
                end
            endcase
        end
    end

endmodule

// File: rtl/obj_list_walker.sv
// Walks one tile's object list in VRAM, one entry per fetch, and emits a
// primitive descriptor per strip/array entry to the ISP parameter parser.
module obj_list_walker
    import pvr_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned MAX_ENTRIES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              list_start,
    input  logic [ADDR_W-1:0] list_addr,
    input  logic [ADDR_W-1:0] param_base,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [31:0]       vram_din,
    input  logic              vram_ack,
    output logic              prim_valid,
    input  logic              prim_ready,
    output logic [ADDR_W-1:0] prim_addr,
    output logic [1:0]        prim_type,
    output logic [5:0]        prim_mask,
    output logic [3:0]        prim_count,
    output logic              prim_shadow,
    output logic [2:0]        prim_skip,
    output logic              list_busy,
    output logic              list_done,
    output logic              list_err
);

    localparam int unsigned CNT_W = $clog2(MAX_ENTRIES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EMIT, FINISH} state_e;

    state_e            r_state;
    logic [31:0]       r_entry;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [ADDR_W-1:0] r_prim_addr;
    logic [CNT_W-1:0]  r_count;
    prim_desc_t        r_desc;
    logic              r_vram_rd;
    logic              r_prim_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    prim_desc_t        w_desc;
    logic [ADDR_W-1:0] w_prim_addr;
    logic [ADDR_W-1:0] w_next_addr;
    entry_kind_e       w_kind;
    logic              w_link_end;
    logic              w_guard;
    logic              w_stop;

    ol_entry_decode #(.ADDR_W(ADDR_W)) u_decode (
        .i_entry      (r_entry),
        .i_param_base (r_base),
        .o_desc       (w_desc),
        .o_prim_addr  (w_prim_addr),
        .o_kind       (w_kind),
        .o_link_end   (w_link_end),
        .o_next_addr  (w_next_addr)
    );

    assign w_guard = (r_count == CNT_W'(MAX_ENTRIES));
    assign w_stop  = w_guard || (w_kind == TYPE_RSVD) || ((w_kind == TYPE_LINK) && w_link_end);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_entry      <= '0;
            r_base       <= '0;
            r_vram_addr  <= '0;
            r_prim_addr  <= '0;
            r_count      <= '0;
            r_desc       <= '0;
            r_vram_rd    <= 1'b0;
            r_prim_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: if (list_start) begin
                    // Masking keeps every list_addr bit in use while forcing word alignment.
                    r_vram_addr <= list_addr & ~ADDR_W'(3);
                    r_base      <= param_base;
                    r_count     <= '0;
                    r_busy      <= 1'b1;
                    r_vram_rd   <= 1'b1;
                    r_state     <= FETCH;
                end
                FETCH: if (vram_ack) begin
                    r_vram_rd <= 1'b0;
                    r_entry   <= vram_din;
                    r_count   <= r_count + CNT_W'(1);
                    r_state   <= DECODE;
                end
                DECODE: begin
                    if (w_stop) begin
                        r_done  <= 1'b1;
                        r_err   <= w_guard || (w_kind == TYPE_RSVD);
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end else if (w_kind == TYPE_LINK) begin
                        r_vram_addr <= w_next_addr;
                        r_vram_rd   <= 1'b1;
                        r_state     <= FETCH;
                    end else if ((w_kind == TYPE_STRIP) && (w_desc.mask == '0)) begin
                        r_vram_addr <= r_vram_addr + ADDR_W'(4);
                        r_vram_rd   <= 1'b1;
                        r_state     <= FETCH;
                    end else begin
                        r_desc       <= w_desc;
                        r_prim_addr  <= w_prim_addr;
                        r_prim_valid <= 1'b1;
                        r_state      <= EMIT;
                    end
                end
                EMIT: if (prim_ready) begin
                    r_prim_valid <= 1'b0;
                    r_vram_addr  <= r_vram_addr + ADDR_W'(4);
                    r_vram_rd    <= 1'b1;
                    r_state      <= FETCH;
                end
                FINISH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vram_rd     = r_vram_rd;
    assign vram_addr   = r_vram_addr;
    assign prim_valid  = r_prim_valid;
    assign prim_addr   = r_prim_addr;
    assign prim_type   = r_desc.ptype;
    assign prim_mask   = r_desc.mask;
    assign prim_count  = r_desc.count;
    assign prim_shadow = r_desc.shadow;
    assign prim_skip   = r_desc.skip;
    assign list_busy   = r_busy;
    assign list_done   = r_done;
    assign list_err    = r_err;

endmodule
